// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller: state encoding,
// one-hot light codes and default phase durations.
package traffic_pkg;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        RED_A     = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        RED_B     = 3'd6,
        WALK      = 3'd7
    } state_e;

    // Light encoding is one-hot {red, yellow, green}.
    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    localparam int COUNT_SIZE_DEF = 5;
    localparam int GREEN_DUR_DEF  = 20;
    localparam int YELLOW_DUR_DEF = 4;
    localparam int ALLRED_DUR_DEF = 2;
    localparam int WALK_DUR_DEF   = 10;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control bus between the phase controller (master) and the saturation timer (slave).
interface traffic_phase_ctrl_if #(
    parameter int COUNT_SIZE = 5
) ();
    logic [COUNT_SIZE-1:0] tmr_count;
    logic                  tmr_load;
    logic                  tmr_down;
    logic [COUNT_SIZE-1:0] tmr_in;
    logic                  tmr_min_load;
    logic [COUNT_SIZE-1:0] tmr_min_in;

    modport master (
        input  tmr_count,
        output tmr_load, tmr_down, tmr_in, tmr_min_load, tmr_min_in
    );

    modport slave (
        output tmr_count,
        input  tmr_load, tmr_down, tmr_in, tmr_min_load, tmr_min_in
    );
endinterface

// File: rtl/phase_light_decode.sv
// Maps a controller state to the NS/EW light codes and the walk indication.
// Walk is only decoded when PED_WALK_EN is defined.
module phase_light_decode
    import traffic_pkg::*;
(
    input  state_e     state,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk
);

    // Light and walk decode for the given state
    always_comb begin
        ns_light = LIGHT_R;
        ew_light = LIGHT_R;
        walk     = 1'b0;
        case (state)
            NS_GREEN:  ns_light = LIGHT_G;
            NS_YELLOW: ns_light = LIGHT_Y;
            EW_GREEN:  ew_light = LIGHT_G;
            EW_YELLOW: ew_light = LIGHT_Y;
`ifdef PED_WALK_EN
            WALK:      walk     = 1'b1;
`endif
            default: begin
                ns_light = LIGHT_R;
                ew_light = LIGHT_R;
            end
        endcase
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic intersection phase sequencer driving an external saturation timer.
// Optional pedestrian walk phase is enabled by defining PED_WALK_EN.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int COUNT_SIZE = COUNT_SIZE_DEF,
    parameter int GREEN_DUR  = GREEN_DUR_DEF,
    parameter int YELLOW_DUR = YELLOW_DUR_DEF,
    parameter int ALLRED_DUR = ALLRED_DUR_DEF,
    parameter int WALK_DUR   = WALK_DUR_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_phase_ctrl_if.master    tmr,
    input  logic                    ew_car,
    input  logic                    ped_req,
    output logic [2:0]              ns_light,
    output logic [2:0]              ew_light,
    output logic                    walk
);

    localparam int MAX_DUR = int'((32'd1 << COUNT_SIZE) - 32'd1);

    if ((GREEN_DUR > MAX_DUR) || (YELLOW_DUR > MAX_DUR) ||
        (ALLRED_DUR > MAX_DUR) || (WALK_DUR > MAX_DUR)) begin : g_dur_too_wide
        $error("traffic_phase_ctrl: a phase duration does not fit in COUNT_SIZE bits");
    end

    localparam logic [COUNT_SIZE-1:0] GREEN_L  = COUNT_SIZE'(GREEN_DUR);
    localparam logic [COUNT_SIZE-1:0] YELLOW_L = COUNT_SIZE'(YELLOW_DUR);
    localparam logic [COUNT_SIZE-1:0] ALLRED_L = COUNT_SIZE'(ALLRED_DUR);
    localparam logic [COUNT_SIZE-1:0] WALK_L   = COUNT_SIZE'(WALK_DUR);

    function automatic logic [COUNT_SIZE-1:0] phase_dur(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   phase_dur = GREEN_L;
            NS_YELLOW, EW_YELLOW: phase_dur = YELLOW_L;
            RED_A, RED_B:         phase_dur = ALLRED_L;
            WALK:                 phase_dur = WALK_L;
            default:              phase_dur = '0;
        endcase
    endfunction

    state_e                state_q, state_d, nxt_s;
    logic                  first_q, first_d;
    logic                  expired_s;
    logic                  tmr_load_q, tmr_load_d;
    logic                  tmr_down_q, tmr_down_d;
    logic                  tmr_min_load_q, tmr_min_load_d;
    logic [COUNT_SIZE-1:0] tmr_in_q, tmr_in_d;
    logic [2:0]            ns_light_q, ns_light_s;
    logic [2:0]            ew_light_q, ew_light_s;
    logic                  walk_q, walk_s;

`ifdef PED_WALK_EN
    logic                  pending_q, pending_d;
`else
    logic                  unused_ped_s;
    assign unused_ped_s = ped_req;
`endif

    // Phase successor on expiry, then state/first-cycle update
    always_comb begin
        nxt_s     = INIT;
        state_d   = state_q;
        first_d   = 1'b0;
        expired_s = ~first_q & (tmr.tmr_count == '0);
        case (state_q)
            NS_GREEN:  nxt_s = ew_car ? NS_YELLOW : NS_GREEN;
            NS_YELLOW: nxt_s = RED_A;
            RED_A:     nxt_s = EW_GREEN;
            EW_GREEN:  nxt_s = EW_YELLOW;
            EW_YELLOW: nxt_s = RED_B;
`ifdef PED_WALK_EN
            RED_B:     nxt_s = pending_q ? WALK : NS_GREEN;
`else
            RED_B:     nxt_s = NS_GREEN;
`endif
            WALK:      nxt_s = NS_GREEN;
            default:   nxt_s = INIT;
        endcase
        // INIT holds once after reset so the floor-load cycle is visible
        if (state_q == INIT) begin
            if (first_q) begin
                state_d = INIT;
                first_d = 1'b0;
            end else begin
                state_d = NS_GREEN;
                first_d = 1'b1;
            end
        end else if (expired_s) begin
            state_d = nxt_s;
            first_d = 1'b1;
        end else begin
            state_d = state_q;
            first_d = 1'b0;
        end
    end

    // Timer control for the upcoming cycle, registered below
    always_comb begin
        tmr_load_d     = first_d & (state_d != INIT);
        tmr_down_d     = ~first_d & (state_d != INIT);
        tmr_min_load_d = ~first_d & (state_d == INIT);
        if (tmr_load_d) begin
            tmr_in_d = phase_dur(state_d);
        end else begin
            tmr_in_d = '0;
        end
    end

`ifdef PED_WALK_EN
    // Sticky pedestrian request; a new request on the clearing cycle is kept
    always_comb begin
        if ((state_d == WALK) && (state_q != WALK)) begin
            pending_d = ped_req;
        end else begin
            pending_d = pending_q | ped_req;
        end
    end
`endif

    phase_light_decode u_decode (
        .state    (state_d),
        .ns_light (ns_light_s),
        .ew_light (ew_light_s),
        .walk     (walk_s)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= INIT;
            first_q        <= 1'b1;
            tmr_load_q     <= 1'b0;
            tmr_down_q     <= 1'b0;
            tmr_min_load_q <= 1'b0;
            tmr_in_q       <= '0;
            ns_light_q     <= LIGHT_R;
            ew_light_q     <= LIGHT_R;
            walk_q         <= 1'b0;
`ifdef PED_WALK_EN
            pending_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            first_q        <= first_d;
            tmr_load_q     <= tmr_load_d;
            tmr_down_q     <= tmr_down_d;
            tmr_min_load_q <= tmr_min_load_d;
            tmr_in_q       <= tmr_in_d;
            ns_light_q     <= ns_light_s;
            ew_light_q     <= ew_light_s;
            walk_q         <= walk_s;
`ifdef PED_WALK_EN
            pending_q      <= pending_d;
`endif
        end
    end

    assign tmr.tmr_load     = tmr_load_q;
    assign tmr.tmr_down     = tmr_down_q;
    assign tmr.tmr_in       = tmr_in_q;
    assign tmr.tmr_min_load = tmr_min_load_q;
    assign tmr.tmr_min_in   = '0;
    assign ns_light         = ns_light_q;
    assign ew_light         = ew_light_q;
    assign walk             = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a behavioural saturation timer.
// Pedestrian sequences follow PED_WALK_EN the same way the design does.
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ew_car = 1'b1;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light, ew_light;
    logic       walk;
    int         errors = 0;
    int         checks = 0;

    traffic_phase_ctrl_if #(.COUNT_SIZE(5)) tif ();

    traffic_phase_ctrl #(
        .COUNT_SIZE(5), .GREEN_DUR(20), .YELLOW_DUR(4), .ALLRED_DUR(2), .WALK_DUR(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tmr      (tif),
        .ew_car   (ew_car),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk)
    );

    always #5 clk = ~clk;

    // Saturating down-counter with loadable floor
    logic [4:0] cnt_m, floor_m;
    assign tif.tmr_count = cnt_m;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_m   <= 5'd0;
            floor_m <= 5'd0;
        end else begin
            if (tif.tmr_min_load) floor_m <= tif.tmr_min_in;
            if (tif.tmr_load) cnt_m <= tif.tmr_in;
            else if (tif.tmr_down && (cnt_m > floor_m)) cnt_m <= cnt_m - 5'd1;
        end
    end

    typedef struct {
        logic       ew_car;
        logic       ped;
        int         n;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic       load;
        logic       down;
        logic       minl;
        logic [4:0] tin;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic e, input logic p, input int n,
                                input logic [2:0] ns, input logic [2:0] ew,
                                input logic w, input logic ld, input logic dn,
                                input logic ml, input logic [4:0] ti);
        vec_t v;
        v.ew_car = e; v.ped = p; v.n = n; v.ns = ns; v.ew = ew;
        v.walk = w; v.load = ld; v.down = dn; v.minl = ml; v.tin = ti;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                             input logic w, input logic ld, input logic dn,
                             input logic ml, input logic [4:0] ti);
        chk({tag, ".ns_light"},     32'(ns_light),         32'(ns));
        chk({tag, ".ew_light"},     32'(ew_light),         32'(ew));
        chk({tag, ".walk"},         32'(walk),             32'(w));
        chk({tag, ".tmr_load"},     32'(tif.tmr_load),     32'(ld));
        chk({tag, ".tmr_down"},     32'(tif.tmr_down),     32'(dn));
        chk({tag, ".tmr_min_load"}, 32'(tif.tmr_min_load), 32'(ml));
        chk({tag, ".tmr_in"},       32'(tif.tmr_in),       32'(ti));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic walk_seen;
        // Cycle numbers in the notes count rising edges after reset release.
        vecs[0]  = mk(1'b1, 1'b0, 0,  LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        vecs[1]  = mk(1'b1, 1'b0, 1,  LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        vecs[2]  = mk(1'b1, 1'b0, 1,  LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20);
        vecs[3]  = mk(1'b1, 1'b0, 1,  LIGHT_G, LIGHT_R, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        vecs[4]  = mk(1'b1, 1'b0, 20, LIGHT_G, LIGHT_R, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);  // 23
        vecs[5]  = mk(1'b1, 1'b0, 1,  LIGHT_Y, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);  // 24
        vecs[6]  = mk(1'b1, 1'b0, 5,  LIGHT_Y, LIGHT_R, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        vecs[7]  = mk(1'b1, 1'b0, 1,  LIGHT_R, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);  // 30
        vecs[8]  = mk(1'b1, 1'b0, 3,  LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        vecs[9]  = mk(1'b1, 1'b0, 1,  LIGHT_R, LIGHT_G, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20); // 34
        vecs[10] = mk(1'b1, 1'b0, 21, LIGHT_R, LIGHT_G, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        vecs[11] = mk(1'b1, 1'b0, 1,  LIGHT_R, LIGHT_Y, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);  // 56
        vecs[12] = mk(1'b1, 1'b0, 5,  LIGHT_R, LIGHT_Y, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        vecs[13] = mk(1'b1, 1'b0, 1,  LIGHT_R, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);  // 62
        vecs[14] = mk(1'b1, 1'b0, 3,  LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        vecs[15] = mk(1'b1, 1'b0, 1,  LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20); // 66
        vecs[16] = mk(1'b0, 1'b0, 21, LIGHT_G, LIGHT_R, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);  // 87
        vecs[17] = mk(1'b0, 1'b0, 1,  LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20); // 88 reload
        vecs[18] = mk(1'b1, 1'b0, 22, LIGHT_Y, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);  // 110

        step(3);
        check_all("in_reset", LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            ew_car  = vecs[i].ew_car;
            ped_req = vecs[i].ped;
            step(vecs[i].n);
            check_all($sformatf("vec%0d", i), vecs[i].ns, vecs[i].ew, vecs[i].walk,
                      vecs[i].load, vecs[i].down, vecs[i].minl, vecs[i].tin);
        end

`ifdef PED_WALK_EN
        step(10);
        check_all("ped_ewg", LIGHT_R, LIGHT_G, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20);      // 120
        step(5); ped_req = 1'b1; step(1); ped_req = 1'b0;                            // 126
        step(22);
        check_all("ped_redb", LIGHT_R, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);      // 148
        step(4);
        check_all("walk_first", LIGHT_R, LIGHT_R, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10);   // 152
        step(11);
        check_all("walk_last", LIGHT_R, LIGHT_R, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);     // 163
        step(1);
        check_all("walk_exit", LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20);    // 164
        step(64);
        check_all("no_repeat", LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20);    // 228
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        step(62);
        check_all("clr_pre", LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);       // 291
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        check_all("walk2", LIGHT_R, LIGHT_R, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10);        // 292
        step(76);
        check_all("walk3_set_wins", LIGHT_R, LIGHT_R, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10); // 368
        step(12);
        check_all("walk3_exit", LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20);   // 380
`else
        ped_req   = 1'b1;
        walk_seen = 1'b0;
        for (int i = 0; i < 42; i++) begin
            step(1);
            if (walk !== 1'b0) walk_seen = 1'b1;
        end
        chk("ped_ignored", 32'(walk_seen), 32'd0);
        check_all("redb_to_nsg", LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20);  // 152
        step(64);
        check_all("redb_to_nsg2", LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20); // 216
        ped_req = 1'b0;
`endif

        // Mid EW_YELLOW: two cycles into the yellow phase
        step(56);
        check_all("rst_pre", LIGHT_R, LIGHT_Y, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        #3 rst = 1'b0;
        #1 check_all("rst_async", LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        check_all("rst_rel", LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1);
        check_all("rst_init", LIGHT_R, LIGHT_R, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        step(1);
        check_all("rst_nsg", LIGHT_G, LIGHT_R, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter: COUNT_SIZE, 5, width of the timer count bus.
REQ-002 Parameter: GREEN_DUR, 20, green phase duration in timer ticks.
REQ-003 Parameter: YELLOW_DUR, 4, yellow phase duration.
REQ-004 Parameter: ALLRED_DUR, 2, all-red clearance duration.
REQ-005 Parameter: WALK_DUR, 10, pedestrian walk duration.
REQ-006 Port: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 Port: rst, input, 1, asynchronous active-low reset.
REQ-008 Port: tmr_count, input, COUNT_SIZE, current count from the saturation timer.
REQ-009 Port: tmr_load, output, 1, load timer with tmr_in.
REQ-010 Port: tmr_down, output, 1, decrement timer.
REQ-011 Port: tmr_in, output, COUNT_SIZE, duration value to load.
REQ-012 Port: tmr_min_load, output, 1, load timer floor with tmr_min_in.
REQ-013 Port: tmr_min_in, output, COUNT_SIZE, timer floor, constant 0.
REQ-014 Port: ew_car, input, 1, level: vehicle waiting on east-west approach.
REQ-015 Port: ped_req, input, 1, pedestrian request, single-cycle or level.
REQ-016 Port: ns_light and ew_light, output, 3 each, one-hot {red,yellow,green}.
REQ-017 Port: walk, output, 1, pedestrian walk signal.

Function
REQ-018 States SHALL be INIT, NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B, WALK.
REQ-019 INIT SHALL last one cycle, assert tmr_min_load=1, then move to NS_GREEN.
REQ-020 On the first cycle in a phase, tmr_load=1 and tmr_in=that phase's duration; tmr_down=0.
REQ-021 On later cycles in the phase, tmr_load=0 and tmr_down=1.
REQ-022 Expiry SHALL be tmr_count==0 on a non-load cycle; the state changes at the following edge.
REQ-023 Phase occupancy SHALL be DUR+2 cycles; DUR=0 gives 2 cycles.
REQ-024 Transition order: NS_GREEN->NS_YELLOW->RED_A->EW_GREEN->EW_YELLOW->RED_B->NS_GREEN.
REQ-025 NS_GREEN expiry with ew_car=0 SHALL re-enter NS_GREEN, reloading GREEN_DUR.
REQ-026 RED_B expiry with a pending pedestrian request SHALL enter WALK instead of NS_GREEN; WALK expiry SHALL enter NS_GREEN.
REQ-027 ped_req SHALL set a sticky pending flag, cleared on WALK entry; a set on the clear cycle wins.
REQ-028 Light mapping: NS_GREEN ns=G,ew=R; NS_YELLOW ns=Y,ew=R; EW_GREEN ns=R,ew=G; EW_YELLOW ns=R,ew=Y; INIT/RED_A/RED_B/WALK both R.
REQ-029 walk=1 only in WALK.
REQ-030 Light outputs SHALL be registered, with no glitches on state change.
REQ-031 Durations wider than COUNT_SIZE SHALL be a compile-time error.

Reset
REQ-032 Asserting rst SHALL immediately force state INIT, both lights red (3'b100), walk=0, tmr_load=0, tmr_down=0, tmr_min_load=0, and pending=0.
REQ-033 Mid-phase reset SHALL abandon the phase; the sequence restarts at INIT after deassertion.

Configuration
REQ-034 Macro PED_WALK_EN: when defined, the pending flag, the WALK state and REQ-026/027 are present.
REQ-035 When PED_WALK_EN is undefined, ped_req SHALL be ignored, walk SHALL be tied 0, and RED_B SHALL always go to NS_GREEN.

Structure
REQ-036 Package traffic_pkg SHALL hold the state enum, light one-hot constants (LIGHT_R/Y/G) and default durations.
REQ-037 Sub-module phase_light_decode SHALL map state to ns_light, ew_light and walk.

Verification
REQ-038 Reset release: INIT for 1 cycle with tmr_min_load=1, then NS_GREEN with tmr_load=1 and tmr_in=20.
REQ-039 ew_car=1 with the timer model: NS_GREEN for 22 cycles, NS_YELLOW for 6, RED_A for 4, then EW_GREEN.
REQ-040 ew_car=0 at NS_GREEN expiry: NS_GREEN reloads (tmr_load=1, tmr_in=20); ns_light stays G.
REQ-041 ped_req pulse during EW_GREEN: after RED_B, WALK with walk=1 for 12 cycles, then NS_GREEN with pending cleared.
REQ-042 rst low mid-EW_YELLOW: outputs go to reset values in the same cycle; after release the sequence restarts at INIT.
REQ-043 PED_WALK_EN undefined: ped_req held 1 never produces walk=1, and RED_B always goes to NS_GREEN.
